// File: rtl/decode_stage_v2.sv
// Decode stage: IF/ID register, register file, immediate extender, forwarding muxes,
// branch comparator and next-PC generation. Define GRF_BYPASS_EN for same-cycle write-to-read bypass.
module decode_stage_v2 #(
  parameter int unsigned NFWD    = 6,
  parameter int unsigned REG_NUM = 32,
  localparam int unsigned FW     = $clog2(NFWD + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          if_instr,
  input  logic [31:0]          if_pc4,
  input  logic                 stall,
  input  logic [2:0]           br_op,
  input  logic [1:0]           jmp_op,
  input  logic [1:0]           ext_op,
  input  logic                 w_en,
  input  logic [4:0]           w_addr,
  input  logic [31:0]          w_data,
  input  logic [FW-1:0]        fwd_sel1,
  input  logic [FW-1:0]        fwd_sel2,
  input  logic [NFWD*32-1:0]   fwd_data,
  output logic [31:0]          d_instr,
  output logic [31:0]          d_pc4,
  output logic                 d_valid,
  output logic [31:0]          rs_val,
  output logic [31:0]          rt_val,
  output logic [31:0]          imm_ext,
  output logic [31:0]          npc,
  output logic                 npc_take,
  output logic                 if_flush
);

  localparam int unsigned AW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  logic [31:0] regs [REG_NUM];
  logic        wr_hit;
  logic [4:0]  addr_a;
  logic [4:0]  addr_b;
  logic [31:0] rf_a;
  logic [31:0] rf_b;
  logic        br_cond;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;

  assign addr_a = d_instr[25:21];
  assign addr_b = d_instr[20:16];
  assign wr_hit = w_en && (w_addr != 5'd0) && (32'(w_addr) < REG_NUM);

  // IF/ID pipeline register: reset > stall hold > flush to bubble > load
  always_ff @(posedge clk) begin
    if (reset) begin
      d_instr <= '0;
      d_pc4   <= '0;
      d_valid <= 1'b0;
    end else if (!stall) begin
      if (if_flush) begin
        d_instr <= '0;
        d_pc4   <= '0;
        d_valid <= 1'b0;
      end else begin
        d_instr <= if_instr;
        d_pc4   <= if_pc4;
        d_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[AW'(w_addr)] <= w_data;
    end
  end

  // Register-file read ports; out-of-range and $0 read as zero
  always_comb begin
    rf_a = '0;
    if ((addr_a != 5'd0) && (32'(addr_a) < REG_NUM)) begin
      rf_a = regs[AW'(addr_a)];
`ifdef GRF_BYPASS_EN
      if (wr_hit && (w_addr == addr_a)) rf_a = w_data;
`endif
    end
  end

  always_comb begin
    rf_b = '0;
    if ((addr_b != 5'd0) && (32'(addr_b) < REG_NUM)) begin
      rf_b = regs[AW'(addr_b)];
`ifdef GRF_BYPASS_EN
      if (wr_hit && (w_addr == addr_b)) rf_b = w_data;
`endif
    end
  end

  // Forwarding muxes; selects above NFWD yield zero
  always_comb begin
    rs_val = '0;
    if (fwd_sel1 == '0) rs_val = rf_a;
    for (int unsigned k = 1; k <= NFWD; k++) begin
      if (fwd_sel1 == FW'(k)) rs_val = fwd_data[32*(k-1) +: 32];
    end
  end

  always_comb begin
    rt_val = '0;
    if (fwd_sel2 == '0) rt_val = rf_b;
    for (int unsigned k = 1; k <= NFWD; k++) begin
      if (fwd_sel2 == FW'(k)) rt_val = fwd_data[32*(k-1) +: 32];
    end
  end

  always_comb begin
    imm_ext = '0;
    case (ext_op)
      2'd0:    imm_ext = {16'h0000, d_instr[15:0]};
      2'd1:    imm_ext = {{16{d_instr[15]}}, d_instr[15:0]};
      2'd2:    imm_ext = {d_instr[15:0], 16'h0000};
      default: imm_ext = '0;
    endcase
  end

  // Zero compares are signed: the sign bit decides
  always_comb begin
    br_cond = 1'b0;
    case (br_op)
      3'd1:    br_cond = (rs_val == rt_val);
      3'd2:    br_cond = (rs_val != rt_val);
      3'd3:    br_cond = rs_val[31] || (rs_val == '0);
      3'd4:    br_cond = !rs_val[31] && (rs_val != '0);
      3'd5:    br_cond = rs_val[31];
      3'd6:    br_cond = !rs_val[31];
      default: br_cond = 1'b0;
    endcase
  end

  assign br_tgt = d_pc4 + {{14{d_instr[15]}}, d_instr[15:0], 2'b00};
  assign j_tgt  = {d_pc4[31:28], d_instr[25:0], 2'b00};

  // Jumps take precedence over branches; reserved jmp_op behaves as no jump
  always_comb begin
    npc_take = 1'b0;
    npc      = '0;
    if (d_valid && !stall) begin
      case (jmp_op)
        2'd1: begin
          npc_take = 1'b1;
          npc      = j_tgt;
        end
        2'd2: begin
          npc_take = 1'b1;
          npc      = rs_val;
        end
        default: begin
          npc_take = br_cond;
          npc      = br_cond ? br_tgt : 32'h0;
        end
      endcase
    end
  end

  assign if_flush = npc_take;

endmodule

// File: tb/tb_decode_stage_v2.sv
// Scoreboard bench for decode_stage_v2: stimulus queues expectations, negedge monitor compares.
module tb_decode_stage_v2;

  localparam int unsigned NFWD = 6;
  localparam int unsigned FW   = 3;

`ifdef GRF_BYPASS_EN
  localparam logic [31:0] BYP_RD = 32'hA5A5_A5A5;
`else
  localparam logic [31:0] BYP_RD = 32'h0000_0001;
`endif

  localparam int unsigned O_INSTR = 0, O_PC4 = 1, O_VALID = 2, O_RS = 3, O_RT = 4,
                          O_IMM = 5, O_NPC = 6, O_TAKE = 7, O_FLUSH = 8;

  logic               clk;
  logic               reset;
  logic [31:0]        if_instr;
  logic [31:0]        if_pc4;
  logic               stall;
  logic [2:0]         br_op;
  logic [1:0]         jmp_op;
  logic [1:0]         ext_op;
  logic               w_en;
  logic [4:0]         w_addr;
  logic [31:0]        w_data;
  logic [FW-1:0]      fwd_sel1;
  logic [FW-1:0]      fwd_sel2;
  logic [NFWD*32-1:0] fwd_data;
  logic [31:0]        d_instr;
  logic [31:0]        d_pc4;
  logic               d_valid;
  logic [31:0]        rs_val;
  logic [31:0]        rt_val;
  logic [31:0]        imm_ext;
  logic [31:0]        npc;
  logic               npc_take;
  logic               if_flush;

  decode_stage_v2 #(.NFWD(NFWD), .REG_NUM(32)) dut (
    .clk(clk), .reset(reset), .if_instr(if_instr), .if_pc4(if_pc4), .stall(stall),
    .br_op(br_op), .jmp_op(jmp_op), .ext_op(ext_op), .w_en(w_en), .w_addr(w_addr),
    .w_data(w_data), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .fwd_data(fwd_data),
    .d_instr(d_instr), .d_pc4(d_pc4), .d_valid(d_valid), .rs_val(rs_val), .rt_val(rt_val),
    .imm_ext(imm_ext), .npc(npc), .npc_take(npc_take), .if_flush(if_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned id;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] dut_out(input int unsigned id);
    case (id)
      O_INSTR: return d_instr;
      O_PC4:   return d_pc4;
      O_VALID: return {31'd0, d_valid};
      O_RS:    return rs_val;
      O_RT:    return rt_val;
      O_IMM:   return imm_ext;
      O_NPC:   return npc;
      O_TAKE:  return {31'd0, npc_take};
      default: return {31'd0, if_flush};
    endcase
  endfunction

  // Monitor: drain expectations queued for the current cycle
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      checks++;
      if (dut_out(mon_e.id) !== mon_e.val) begin
        failures++;
        $display("FAIL %s: got %h want %h (t=%0t)", mon_e.name, dut_out(mon_e.id), mon_e.val, $time);
      end
    end
  end

  task automatic expect_out(input int unsigned id, input logic [31:0] v, input string n);
    exp_t e;
    e.id = id; e.val = v; e.name = n;
    sbq.push_back(e);
  endtask

  task automatic defaults();
    if_instr = '0; if_pc4 = '0; stall = 1'b0; br_op = '0; jmp_op = '0; ext_op = '0;
    w_en = 1'b0; w_addr = '0; w_data = '0; fwd_sel1 = '0; fwd_sel2 = '0; fwd_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, 16'h0000};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  localparam logic [31:0] JR_I  = {6'd0, 5'd31, 15'd0, 6'd8};
  localparam logic [31:0] J_I   = {6'd2, 26'h000_0100};

  initial begin
    logic [31:0] beq_s;
    beq_s = itype(6'd4, 5'd4, 5'd4, 16'h0003);

    // Reset for two cycles
    defaults(); reset = 1'b1; step();
    defaults(); reset = 1'b1;
    expect_out(O_INSTR, 32'h0, "rst_d_instr");
    expect_out(O_VALID, 32'h0, "rst_d_valid");
    expect_out(O_RS,    32'h0, "rst_rs_val");
    expect_out(O_TAKE,  32'h0, "rst_npc_take");
    expect_out(O_NPC,   32'h0, "rst_npc");
    expect_out(O_FLUSH, 32'h0, "rst_if_flush");
    step();
    reset = 1'b0;

    // Every register reads zero after reset
    for (int i = 0; i <= 16; i++) begin
      defaults();
      if (i < 16) if_instr = rtype(5'(2*i), 5'(2*i+1));
      if (i > 0) begin
        expect_out(O_RS,    32'h0, "sweep_rs");
        expect_out(O_RT,    32'h0, "sweep_rt");
        expect_out(O_VALID, 32'h1, "sweep_valid");
      end
      step();
    end

    // Write $8, then attempt to write $0
    defaults(); w_en = 1'b1; w_addr = 5'd8; w_data = 32'h0000_1234; step();
    defaults(); w_en = 1'b1; w_addr = 5'd0; w_data = 32'hFFFF_FFFF; if_instr = rtype(5'd8, 5'd0); step();
    defaults();
    expect_out(O_INSTR, rtype(5'd8, 5'd0), "rf_d_instr");
    expect_out(O_RS,    32'h0000_1234,     "rf_read_r8");
    expect_out(O_RT,    32'h0,             "rf_read_r0");
    if_instr = itype(6'd4, 5'd1, 5'd2, 16'hFFFE); if_pc4 = 32'h0000_3008;
    step();

    // Taken beq, both operands forwarded from source 1
    defaults();
    br_op = 3'd1; fwd_sel1 = 3'd2; fwd_sel2 = 3'd2; fwd_data[63:32] = 32'h55; ext_op = 2'd1;
    if_instr = 32'hDEAD_BEEF; if_pc4 = 32'h0000_300C;
    expect_out(O_RS,    32'h55,        "beq_rs_fwd");
    expect_out(O_RT,    32'h55,        "beq_rt_fwd");
    expect_out(O_PC4,   32'h3008,      "beq_d_pc4");
    expect_out(O_TAKE,  32'h1,         "beq_take");
    expect_out(O_NPC,   32'h3000,      "beq_npc");
    expect_out(O_FLUSH, 32'h1,         "beq_flush");
    expect_out(O_IMM,   32'hFFFF_FFFE, "imm_sext");
    step();

    defaults();
    expect_out(O_VALID, 32'h0, "flush_valid");
    expect_out(O_INSTR, 32'h0, "flush_instr");
    expect_out(O_PC4,   32'h0, "flush_pc4");
    expect_out(O_TAKE,  32'h0, "flush_take");
    if_instr = itype(6'd1, 5'd3, 5'd0, 16'h0010); if_pc4 = 32'h0000_4000;
    step();

    // bltz on 0x8000_0000
    defaults();
    br_op = 3'd5; fwd_sel1 = 3'd1; fwd_data[31:0] = 32'h8000_0000; ext_op = 2'd2;
    if_instr = 32'h1234_5678; if_pc4 = 32'h0000_4004;
    expect_out(O_TAKE, 32'h1,         "bltz_take");
    expect_out(O_NPC,  32'h4040,      "bltz_npc");
    expect_out(O_IMM,  32'h0010_0000, "imm_lui");
    step();

    // Bubble in D never redirects even if the condition holds
    defaults();
    br_op = 3'd6;
    expect_out(O_TAKE,  32'h0, "bubble_take");
    expect_out(O_FLUSH, 32'h0, "bubble_flush");
    expect_out(O_VALID, 32'h0, "bubble_valid");
    if_instr = itype(6'd7, 5'd0, 5'd0, 16'h0020); if_pc4 = 32'h0000_5000;
    step();

    // bgtz with rs = 0 is not taken
    defaults();
    br_op = 3'd4;
    expect_out(O_RS,   32'h0,  "bgtz_rs");
    expect_out(O_TAKE, 32'h0,  "bgtz_take");
    expect_out(O_NPC,  32'h0,  "bgtz_npc");
    expect_out(O_IMM,  32'h20, "imm_zext");
    if_instr = JR_I; if_pc4 = 32'h0000_6000;
    step();

    // jr from source 0, with a true bne that must lose to the jump
    defaults();
    jmp_op = 2'd2; br_op = 3'd2; fwd_sel1 = 3'd1; fwd_data[31:0] = 32'h0000_3400; ext_op = 2'd3;
    if_instr = 32'hCAFE_F00D;
    expect_out(O_TAKE, 32'h1,    "jr_take");
    expect_out(O_NPC,  32'h3400, "jr_npc");
    expect_out(O_IMM,  32'h0,    "imm_zero");
    step();

    defaults(); if_instr = J_I; if_pc4 = 32'h9000_0004; step();

    defaults();
    jmp_op = 2'd1;
    expect_out(O_TAKE, 32'h1,         "j_take");
    expect_out(O_NPC,  32'h9000_0400, "j_npc");
    step();

    defaults(); if_instr = beq_s; if_pc4 = 32'h0000_7000; step();

    // Taken beq held by stall for three cycles
    for (int i = 0; i < 3; i++) begin
      defaults();
      stall = 1'b1; br_op = 3'd1; if_instr = 32'h0BAD_0BAD; if_pc4 = 32'h0000_7004;
      expect_out(O_TAKE,  32'h0,  "stall_take");
      expect_out(O_FLUSH, 32'h0,  "stall_flush");
      expect_out(O_INSTR, beq_s,  "stall_instr");
      expect_out(O_VALID, 32'h1,  "stall_valid");
      step();
    end

    defaults();
    br_op = 3'd1;
    expect_out(O_TAKE,  32'h1,    "unstall_take");
    expect_out(O_NPC,   32'h700C, "unstall_npc");
    expect_out(O_FLUSH, 32'h1,    "unstall_flush");
    expect_out(O_PC4,   32'h7000, "unstall_pc4");
    step();

    // Same-cycle write and read of $5
    defaults(); w_en = 1'b1; w_addr = 5'd5; w_data = 32'h1; if_instr = rtype(5'd5, 5'd8); step();
    defaults();
    w_en = 1'b1; w_addr = 5'd5; w_data = 32'hA5A5_A5A5; if_instr = rtype(5'd5, 5'd8);
    expect_out(O_RS, BYP_RD,        "bypass_rs");
    expect_out(O_RT, 32'h0000_1234, "bypass_rt");
    step();

    // Reset mid-operation
    defaults(); reset = 1'b1;
    expect_out(O_RS, 32'hA5A5_A5A5, "after_write_rs");
    step();
    reset = 1'b0;
    defaults();
    expect_out(O_VALID, 32'h0, "midrst_valid");
    expect_out(O_INSTR, 32'h0, "midrst_instr");
    expect_out(O_TAKE,  32'h0, "midrst_take");
    if_instr = rtype(5'd8, 5'd5);
    step();

    // Cleared registers, reserved forward select and reserved branch op
    defaults();
    fwd_sel2 = 3'd7; fwd_data = '1; br_op = 3'd7;
    expect_out(O_RS,   32'h0, "midrst_r8");
    expect_out(O_RT,   32'h0, "rsvd_fwd_sel");
    expect_out(O_TAKE, 32'h0, "rsvd_br_op");
    step();

    defaults();
    step();
    step();
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage_v2.md
# decode_stage_v2

Parametrised decode (D) stage for the five-stage MIPS pipeline CPU. It owns the IF/ID pipeline register, the general register file, the immediate extender, N-source forwarding muxes for both read ports, a multi-mode branch comparator and next-PC generation. Branches and jumps resolve in D with no delay slot: a taken branch flushes the wrong-path instruction. This extends the fixed beq/j/jal decode stage with selectable branch modes, register-indirect jumps and a configurable forwarding-source count.

## Interface
Parameters:
- NFWD, 6, number of forwarding sources (1..7); select width FW = clog2(NFWD+1)
- REG_NUM, 32, implemented registers (8, 16 or 32); addresses >= REG_NUM read 0, writes ignored

Ports:
- clk  in  1  clock; single clock domain, rising edge
- reset  in  1  synchronous, active-high reset
- if_instr  in  32  instruction from fetch
- if_pc4  in  32  PC+4 from fetch
- stall  in  1  hazard-unit stall: hold IF/ID, suppress redirect
- br_op  in  3  0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 reserved (never taken)
- jmp_op  in  2  0 none, 1 j/jal (26-bit target), 2 jr/jalr (rs), 3 reserved (none)
- ext_op  in  2  0 zero-ext, 1 sign-ext, 2 imm16<<16, 3 zero
- w_en, w_addr[4:0], w_data[31:0]  in  write-back port from W
- fwd_sel1, fwd_sel2  in  FW  0 = register file, k = fwd_data source k-1
- fwd_data  in  NFWD*32  forwarded values; source k at bits [32k+31:32k]
- d_instr, d_pc4  out  32  IF/ID register contents
- d_valid  out  1  IF/ID holds a real instruction
- rs_val, rt_val  out  32  forwarded operand values
- imm_ext  out  32  extended immediate
- npc  out  32  redirect target
- npc_take  out  1  redirect fetch to npc
- if_flush  out  1  squash instruction currently in fetch

## Operation
- IF/ID register, on each rising edge, in priority order: reset -> d_instr=0, d_pc4=0, d_valid=0. stall -> hold. if_flush -> d_instr=0 (nop), d_pc4=0, d_valid=0. Otherwise load if_instr, if_pc4, d_valid=1.
- Register file: REG_NUM x 32. Reset clears all entries to 0. Write on a rising edge when w_en && w_addr!=0 && w_addr<REG_NUM. Register 0 always reads 0.
- Read ports A1=d_instr[25:21], A2=d_instr[20:16]. rs_val/rt_val = mux(fwd_sel, regfile, fwd_data). Reserved selects (> NFWD) output 0.
- Comparator on rs_val/rt_val, signed for the zero compares: beq A==B; bne A!=B; blez A<=0; bgtz A>0; bltz A<0; bgez A>=0.
- Branch target = d_pc4 + (sext(d_instr[15:0])<<2), 32-bit wrap-around. j target = {d_pc4[31:28], d_instr[25:0], 2'b00}. jr target = rs_val.
- npc_take = d_valid && !stall && (jmp_op in {1,2} || branch condition true). jmp_op takes precedence over br_op. npc = jump target if jmp_op!=0, else branch target. npc = 0 when npc_take=0.
- if_flush = npc_take.

## Timing
- Register-file read, forwarding, comparator, npc, npc_take, if_flush and imm_ext are combinational from IF/ID state and inputs. Redirect is 0 cycles after the instruction enters D.
- Write-to-read: a W write is visible to a register-file read the next cycle, unless GRF_BYPASS_EN is defined.
- Stall and taken branch together: the stall wins. No redirect and no flush occur. The branch re-evaluates on the first unstalled cycle.
- Reset mid-operation: the IF/ID register and the register file are both cleared on the same edge. npc_take=0 in the following cycle.
- All outputs after reset: 0.

## Configuration
- GRF_BYPASS_EN defined: a read of an address being written in the same cycle (w_en, matching, non-zero, in range) returns w_data. This removes the W-stage forwarding requirement.
- GRF_BYPASS_EN undefined: the same read returns the old register value. The hazard unit must select a W forward source instead.

## Test plan
- Reset for 2 cycles -> d_instr=0, d_valid=0, rs_val=0, npc_take=0, and every register reads 0.
- Write $8=0x0000_1234. Next cycle load an instruction with rs=8 and fwd_sel1=0 -> rs_val=0x0000_1234. Also write $0=0xFFFF_FFFF -> $0 still reads 0.
- d_pc4=0x3008, beq with fwd_sel1=fwd_sel2=2 and source 1 = 0x55 on both ports, imm=0xFFFE -> npc_take=1, npc=0x3000, if_flush=1. Next cycle d_valid=0, d_instr=0.
- bltz with rs=0x8000_0000 -> taken. bgtz with rs=0 -> not taken. jr with rs forwarded from source 0 = 0x3400 -> npc=0x3400.
- Taken beq with stall held for 3 cycles -> d_instr unchanged and npc_take=0 throughout. npc_take=1 in the cycle the stall drops.
- w_en=1, w_addr=5, w_data=0xA5A5_A5A5 in the same cycle as a read of $5 holding 0x1 -> rs_val=0xA5A5_A5A5 with GRF_BYPASS_EN, 0x1 without.
